// File: rtl/risc16_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// risc16_fetch_sequencer
//
// Front end of the RiSC16 processor. It owns the program counter and fetches
// one instruction word at a time over a req/ack memory port. It also holds the
// fetched word in an instruction register and presents the op/state/pen inputs
// that RiSC16_control decodes. At the end of the single EXECUTE cycle the
// control unit's muxPc select decides the next PC. The value 11 halts the
// machine. Execution resumes at pc+1 on the next start pulse.
//
// Ports:
//   clk       rising-edge system clock
//   rst       synchronous active-high reset (wins over every other input)
//   start     begin/resume execution; only looked at in IDLE or HALTED
//   muxPc     next-PC select: 00 pc+1, 01 br_tgt, 10 jmp_tgt, 11 halt (pc+1)
//   br_tgt    externally computed branch target
//   jmp_tgt   register jump target (JALR)
//   i_req     instruction fetch request, held until i_ack
//   i_addr    fetch address (always equal to pc)
//   i_ack     fetch complete, i_data valid in this cycle
//   i_data    fetched instruction word
//   pc        address of the instruction held in instr
//   pc_plus1  pc+1 modulo 2^ADDR_WIDTH (JALR link value)
//   instr     instruction register
//   op        opcode field, top OP_LEN bits of instr
//   state     0 = FETCH phase, 1 = EXECUTE phase
//   pen       processor enable, high in FETCH and EXECUTE
// -----------------------------------------------------------------------------
module risc16_fetch_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int OP_LEN     = 3,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            muxPc,
  input  logic [ADDR_WIDTH-1:0] br_tgt,
  input  logic [ADDR_WIDTH-1:0] jmp_tgt,
  output logic                  i_req,
  output logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_ack,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [OP_LEN-1:0]     op,
  output logic                  state,
  output logic                  pen
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    EXECUTE = 2'd2,
    HALTED  = 2'd3
  } fsmState_t;

  fsmState_t             fsmReg;
  logic [ADDR_WIDTH-1:0] pcReg;
  logic [ADDR_WIDTH-1:0] pcPlus1;
  logic [DATA_WIDTH-1:0] instrReg;
  logic                  stateReg;
  logic                  penReg;
  logic                  iReqReg;

  // Natural wrap of the adder gives the required modulo-2^ADDR_WIDTH increment.
  assign pcPlus1 = pcReg + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsmReg   <= IDLE;
      pcReg    <= ADDR_WIDTH'(RESET_PC);
      instrReg <= '0;
      stateReg <= 1'b0;
      penReg   <= 1'b0;
      iReqReg  <= 1'b0;
    end else begin
      case (fsmReg)
        // IDLE and HALTED behave identically: pc already points at the next
        // instruction to run (RESET_PC, or the word after the halt).
        IDLE, HALTED: begin
          if (start) begin
            fsmReg   <= FETCH;
            stateReg <= 1'b0;
            penReg   <= 1'b1;
            iReqReg  <= 1'b1;
          end
        end
        FETCH: begin
          // Without an ack everything holds, so the wait is unbounded.
          if (i_ack) begin
            instrReg <= i_data;
            fsmReg   <= EXECUTE;
            stateReg <= 1'b1;
            iReqReg  <= 1'b0;
          end
        end
        EXECUTE: begin
          stateReg <= 1'b0;
          case (muxPc)
            2'b01:   pcReg <= br_tgt;
            2'b10:   pcReg <= jmp_tgt;
            default: pcReg <= pcPlus1;  // 00 and the halt encoding 11
          endcase
          if (muxPc == 2'b11) begin
            fsmReg  <= HALTED;
            penReg  <= 1'b0;
            iReqReg <= 1'b0;
          end else begin
            fsmReg  <= FETCH;
            iReqReg <= 1'b1;
          end
        end
        default: fsmReg <= IDLE;
      endcase
    end
  end

  assign i_req    = iReqReg;
  assign i_addr   = pcReg;
  assign pc       = pcReg;
  assign pc_plus1 = pcPlus1;
  assign instr    = instrReg;
  assign state    = stateReg;
  assign pen      = penReg;

  // Opcode is the most significant OP_LEN bits of the instruction register.
  for (genvar gi = 0; gi < OP_LEN; gi++) begin : gen_op
    assign op[gi] = instrReg[DATA_WIDTH-OP_LEN+gi];
  end

endmodule

// File: tb/tb_risc16_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_risc16_fetch_sequencer
//
// Scoreboard bench. The stimulus process plays instruction memory and control
// unit. It keeps its own program-counter model and pushes the expected fetch
// addresses, execute records and halt records into queues. An independent
// monitor pops and compares whenever the DUT starts a fetch, sits in EXECUTE,
// or drops pen after an EXECUTE.
// -----------------------------------------------------------------------------
module tb_risc16_fetch_sequencer;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int OPL = 3;
  localparam int RPC = 0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    muxPc = 2'b00;
  logic [AW-1:0] br_tgt = '0;
  logic [AW-1:0] jmp_tgt = '0;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus1;
  logic [DW-1:0] instr;
  logic [OPL-1:0] op;
  logic          state;
  logic          pen;

  risc16_fetch_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OP_LEN(OPL), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .muxPc(muxPc),
    .br_tgt(br_tgt), .jmp_tgt(jmp_tgt),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .pc(pc), .pc_plus1(pc_plus1), .instr(instr), .op(op),
    .state(state), .pen(pen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  rec_t          fetchQ[$];   // expected fetch addresses (data unused)
  rec_t          execQ[$];    // expected {pc, instr} during EXECUTE
  rec_t          haltQ[$];    // expected {pc, instr} on entering HALTED
  logic [AW-1:0] modelPc;
  logic [DW-1:0] lastInstr = '0;
  bit            abortRun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic          prevReq = 1'b0;
  logic          prevState = 1'b0;
  logic [AW-1:0] curFetch = '0;

  always @(negedge clk) begin
    if (rst) begin
      prevReq   = 1'b0;
      prevState = 1'b0;
      curFetch  = AW'(RPC);
    end else begin
      if (i_req && !prevReq) begin
        if (fetchQ.size() == 0) begin
          check("fetch_unexpected", 32'(i_addr), 32'hFFFF_FFFF);
        end else begin
          rec_t f;
          f = fetchQ.pop_front();
          curFetch = f.pc;
          check("fetch_addr", 32'(i_addr), 32'(f.pc));
          check("fetch_pc_plus1", 32'(pc_plus1), 32'(AW'(f.pc + 1'b1)));
          check("fetch_pen", 32'(pen), 32'd1);
        end
      end
      if (i_req) begin
        check("wait_state", 32'(state), 32'd0);
        check("wait_pc", 32'(pc), 32'(curFetch));
        check("wait_instr", 32'(instr), 32'(lastInstr));
      end
      if (state) begin
        if (execQ.size() == 0) begin
          check("exec_unexpected", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          rec_t e;
          e = execQ.pop_front();
          check("exec_pc", 32'(pc), 32'(e.pc));
          check("exec_instr", 32'(instr), 32'(e.data));
          check("exec_op", 32'(op), 32'(e.data[DW-1 -: OPL]));
          check("exec_req", 32'(i_req), 32'd0);
          check("exec_pen", 32'(pen), 32'd1);
          lastInstr = e.data;
          $display("exec pc=%h instr=%h op=%0d", pc, instr, op);
        end
      end
      if (prevState && !pen) begin
        if (haltQ.size() == 0) begin
          check("halt_unexpected", 32'(pc), 32'hFFFF_FFFF);
        end else begin
          rec_t h;
          h = haltQ.pop_front();
          check("halt_pc", 32'(pc), 32'(h.pc));
          check("halt_instr", 32'(instr), 32'(h.data));
          $display("halt pc=%h", pc);
        end
      end
      if (!pen) begin
        check("idle_req", 32'(i_req), 32'd0);
        check("idle_instr", 32'(instr), 32'(lastInstr));
      end
      prevReq   = i_req;
      prevState = state;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic waitReq();
    int n = 0;
    while (!i_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!i_req) begin
      check("req_timeout", 32'(i_req), 32'd1);
      abortRun = 1'b1;
    end
  endtask

  // One instruction: fetch with ack after `delay` wait cycles, then execute
  // with the given select. Returns at the negedge after the EXECUTE edge (or
  // after the resume start pulse, for a halt).
  task automatic runInstr(input int delay, input logic [DW-1:0] data,
                          input logic [1:0] sel, input logic [AW-1:0] tgt);
    logic [AW-1:0] nextPc;
    rec_t r;
    waitReq();
    if (abortRun) return;
    for (int d = 0; d < delay; d++) begin
      start = ($urandom_range(0, 2) == 0);  // start in FETCH must be ignored
      @(negedge clk);
    end
    start  = 1'b0;
    i_ack  = 1'b1;
    i_data = data;
    r.pc = modelPc; r.data = data;
    execQ.push_back(r);
    @(negedge clk);
    i_ack   = 1'b0;
    i_data  = DW'($urandom);
    muxPc   = sel;
    br_tgt  = (sel == 2'b01) ? tgt : AW'($urandom);
    jmp_tgt = (sel == 2'b10) ? tgt : AW'($urandom);
    case (sel)
      2'b01:   nextPc = tgt;
      2'b10:   nextPc = tgt;
      default: nextPc = modelPc + 1'b1;
    endcase
    r.pc = nextPc; r.data = data;
    fetchQ.push_back(r);
    if (sel == 2'b11) haltQ.push_back(r);
    modelPc = nextPc;
    @(negedge clk);
    muxPc   = 2'($urandom);   // outside EXECUTE muxPc must be ignored
    br_tgt  = AW'($urandom);
    jmp_tgt = AW'($urandom);
    if (sel == 2'b11) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        i_ack  = 1'b1;       // acks while halted must be ignored
        i_data = DW'($urandom);
        @(negedge clk);
      end
      i_ack = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  logic [1:0]    dSel[7]   = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [AW-1:0] dTgt[7]   = '{16'h0000, 16'h0040, 16'h1234, 16'hFFFF, 16'h0000, 16'h0005, 16'h0000};
  int            dDelay[7] = '{0, 3, 1, 0, 2, 0, 1};

  initial begin
    modelPc = AW'(RPC);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pen", 32'(pen), 32'd0);
    check("rst_req", 32'(i_req), 32'd0);
    check("rst_pc", 32'(pc), 32'(RPC));
    check("rst_addr", 32'(i_addr), 32'(RPC));
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    start = 1'b1;                 // start together with rst: stays IDLE
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", 32'(i_req), 32'd0);

    r_push_start();

    for (int i = 0; i < 7 && !abortRun; i++)
      runInstr(dDelay[i], (i == 0) ? 16'h2481 : DW'($urandom), dSel[i], dTgt[i]);

    for (int i = 0; i < 30 && !abortRun; i++) begin
      int w;
      logic [1:0] sel;
      w = $urandom_range(0, 9);
      sel = (w < 5) ? 2'b00 : (w < 7) ? 2'b01 : (w < 9) ? 2'b10 : 2'b11;
      runInstr($urandom_range(0, 3), DW'($urandom), sel, AW'($urandom));
    end

    // Reset during FETCH coincident with an ack.
    if (!abortRun) begin
      waitReq();
      @(negedge clk);
      rst    = 1'b1;
      i_ack  = 1'b1;
      i_data = 16'hFFFF;
      @(negedge clk);
      lastInstr = '0;
      check("fetch_rst_instr", 32'(instr), 32'd0);
      check("fetch_rst_pc", 32'(pc), 32'(RPC));
      check("fetch_rst_req", 32'(i_req), 32'd0);
      check("fetch_rst_pen", 32'(pen), 32'd0);
      check("fetch_rst_state", 32'(state), 32'd0);
      fetchQ.delete();
      modelPc = AW'(RPC);
      @(negedge clk);
      rst   = 1'b0;
      i_ack = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 32'(i_req), 32'd0);
      r_push_start();
      runInstr(3, 16'h2481, 2'b00, 16'h0000);
      repeat (3) @(negedge clk);
      check("post_rst_next_pc", 32'(i_addr), 32'(AW'(RPC + 1)));
    end

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(execQ.size() + haltQ.size() + fetchQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic r_push_start();
    rec_t r;
    r.pc = modelPc; r.data = '0;
    fetchQ.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

endmodule
